// File: rtl/dequantize_unit_pkg.sv
// dequantize_unit_pkg
// Shared definitions for the dequantize unit: FSM state encoding, field
// positions inside the packed params word, and fixed-point constants.
package dequantize_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // params word layout: [31:16] unsigned scale Q8.8, [15:0] signed zero point
    localparam int SCALE_MSB  = 31;
    localparam int SCALE_LSB  = 16;
    localparam int ZP_MSB     = 15;
    localparam int ZP_LSB     = 0;

    // Fractional bits of the Q8.8 scale
    localparam int SCALE_FRAC = 8;

    // Width of one packed int8 element
    localparam int BYTE_W     = 8;

endpackage

// File: rtl/dequantize_unit_unpacker.sv
// byte_unpacker
// Holds one packed 32-bit input word and issues its int8 elements one per
// unstalled cycle, byte0 first. Only the first last_idx+1 bytes of a word
// are issued, so the tail of a partial final word is discarded.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   load         capture word (only asserted while empty)
//   word         packed input word
//   last_idx     index of the last byte of word to issue (0..3)
//   stall        downstream pipeline is frozen this cycle
//   byte_valid   an unissued byte is held
//   byte_data    current byte
//   issue        byte is handed to the pipeline this cycle
//   empty        no unissued byte held
module byte_unpacker
    import dequantize_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word,
    input  logic [1:0]  last_idx,
    input  logic        stall,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        issue,
    output logic        empty
);

    logic [31:0] word_q;
    logic [1:0]  idx;
    logic [1:0]  last_q;
    logic        has_data;

    assign byte_valid = has_data;
    assign empty      = !has_data;
    assign issue      = has_data && !stall;
    assign byte_data  = word_q[idx*BYTE_W +: BYTE_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            has_data <= 1'b0;
            idx      <= 2'd0;
        end else if (load) begin
            has_data <= 1'b1;
            idx      <= 2'd0;
        end else if (issue) begin
            if (idx == last_q) begin
                has_data <= 1'b0;
            end else begin
                idx <= idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            word_q <= word;
            last_q <= last_idx;
        end
    end

endmodule

// File: rtl/dequantize_unit.sv
// dequantize_unit
// Converts a packed int8 stream into signed fixed-point values:
//   out = ((sext(q) - zero_point) * scale) << (OUT_FRAC - 8)
// A job is launched by start in IDLE with params/size latched; the input
// stream carries four elements per word, byte0 first.
// Optional feature: define DEQUANT_SAT_EN to saturate results to the signed
// 32-bit range; otherwise the low 32 bits are kept (wrap).
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start                       job launch (sampled only in IDLE)
//   params                      [31:16] scale Q8.8, [15:0] signed zero point
//   size                        element count of the job
//   in_data/in_valid/in_ready   packed int8 input stream
//   out_data/out_valid/out_ready result stream, signed Q(32-OUT_FRAC).OUT_FRAC
//   busy                        high in every state except IDLE
//   done                        one-cycle completion pulse
module dequantize_unit
    import dequantize_unit_pkg::*;
#(
    parameter int OUT_FRAC = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] params,
    input  logic [31:0] size,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam int SHIFT = OUT_FRAC - SCALE_FRAC;
    localparam int RES_W = 33 + SHIFT;

    state_t      state, state_next;
    logic [31:0] params_q, size_q;
    logic [31:0] words_acc, issue_cnt, words_total;
    logic        last_word, load, stall, last_issue;
    logic [1:0]  last_idx;
    logic        byte_valid, issue, empty;
    logic [7:0]  byte_data;

    logic                    vld_p1;
    logic signed [16:0]      diff_p1;
    logic signed [32:0]      prod;
    logic signed [RES_W-1:0] res;

    function automatic logic [31:0] fit_res(input logic signed [RES_W-1:0] r);
`ifdef DEQUANT_SAT_EN
        logic signed [RES_W-1:0] max_v;
        logic signed [RES_W-1:0] min_v;
        max_v = RES_W'(64'sh7FFFFFFF);
        min_v = RES_W'(-64'sh80000000);
        if (r > max_v) begin
            return 32'h7FFFFFFF;
        end else if (r < min_v) begin
            return 32'h80000000;
        end
        return 32'(r);
`else
        return 32'(r);
`endif
    endfunction

    // A partial final word carries size[1:0] valid bytes
    assign words_total = (size_q >> 2) + {31'd0, |size_q[1:0]};
    assign last_word   = (words_acc == words_total - 32'd1);
    assign last_idx    = (last_word && size_q[1:0] != 2'd0) ? size_q[1:0] - 2'd1 : 2'd3;
    assign stall       = out_valid && !out_ready;
    assign in_ready    = (state == RUN) && empty && (words_acc < words_total);
    assign load        = in_valid && in_ready;
    assign last_issue  = issue && (issue_cnt == size_q - 32'd1);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (size == 32'd0) ? DONE : RUN;
            RUN:     if (last_issue) state_next = DRAIN;
            // With stage 1 empty, the result leaving stage 2 is the last one
            DRAIN:   if (out_valid && out_ready && !vld_p1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            params_q  <= 32'd0;
            size_q    <= 32'd0;
            words_acc <= 32'd0;
            issue_cnt <= 32'd0;
        end else if (state == IDLE && start) begin
            params_q  <= params;
            size_q    <= size;
            words_acc <= 32'd0;
            issue_cnt <= 32'd0;
        end else begin
            if (load)  words_acc <= words_acc + 32'd1;
            if (issue) issue_cnt <= issue_cnt + 32'd1;
        end
    end

    byte_unpacker u_unpacker (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .word       (in_data),
        .last_idx   (last_idx),
        .stall      (stall),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .issue      (issue),
        .empty      (empty)
    );

    // Stage 1: subtract zero point
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= byte_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            diff_p1 <= {{9{byte_data[7]}}, byte_data}
                     - {params_q[ZP_MSB], params_q[ZP_MSB:ZP_LSB]};
        end
    end

    // Low 33 bits of the unsigned product equal the signed product; the
    // true value always fits in 33 bits.
    assign prod = {{16{diff_p1[16]}}, diff_p1} * {17'd0, params_q[SCALE_MSB:SCALE_LSB]};
    assign res  = RES_W'(prod) <<< SHIFT;

    // Stage 2: scale, align and fit to 32 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 32'd0;
        end else if (!stall) begin
            out_valid <= vld_p1;
            out_data  <= fit_res(res);
        end
    end

endmodule
